// File: rtl/burst_grant_pkg.sv
// Shared definitions for the burst grant controller: FSM state encoding and default sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package burst_grant_pkg;

  localparam int NUM_GRANTS_DEF = 3;
  localparam int GAP_W_DEF      = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_GRANT = 3'd2,
    ST_CHECK = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/gap_timer.sv
// Inter-grant gap countdown: loaded with the gap length, counts down while enabled.
// Latency: o_expire is combinational on the count; it is high in the last enabled cycle of a g-cycle gap.
// Backpressure: none; i_load takes priority over counting and is never refused.
module gap_timer
  import burst_grant_pkg::*;
#(
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [GAP_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expire
);

  logic [GAP_W-1:0] r_cnt;

  // Reload on a new gap, otherwise count down while the controller sits in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - GAP_W'(1);
    end
  end

  // A count of 1 marks the final idle cycle, so a gap of g lasts exactly g cycles.
  assign o_expire = i_en && (r_cnt == GAP_W'(1));

endmodule

// File: rtl/burst_grant_ctrl.sv
// Issues NUM_GRANTS single-cycle grants per accepted request, each preceded by gap_q idle cycles.
// Latency: grant n appears n*(gap_q+1) cycles after acceptance; done/abort one cycle after the deciding sample.
// Backpressure: none; the requester holds req until completion, dropping early aborts the burst.
module burst_grant_ctrl
  import burst_grant_pkg::*;
#(
  parameter int NUM_GRANTS = NUM_GRANTS_DEF,
  parameter int GAP_W      = GAP_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req,
  input  logic [GAP_W-1:0]                  gap_cfg,
  input  logic                              clr_err,
  output logic                              grant,
  output logic [$clog2(NUM_GRANTS+1)-1:0]   grant_cnt,
  output logic                              done,
  output logic                              abort,
  output logic                              proto_err,
  output logic                              busy
);

  localparam int CNT_W = $clog2(NUM_GRANTS + 1);

  state_t             r_state;
  logic [GAP_W-1:0]   r_gap_q;
  logic               r_grant;
  logic [CNT_W-1:0]   r_grant_cnt;
  logic               r_done;
  logic               r_abort;
  logic               r_proto_err;
  logic               r_busy;

  logic               w_final;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_tmr_load;
  logic [GAP_W-1:0]   w_tmr_val;
  logic               w_tmr_expire;

  // grant_cnt already counts the grant being shown, so equality marks the last grant of the burst.
  assign w_final   = (r_grant_cnt == CNT_W'(NUM_GRANTS));
  assign w_cnt_inc = w_final ? r_grant_cnt : (r_grant_cnt + CNT_W'(1));

  // The timer is armed on every transition into WAIT: from IDLE with the live config, later from gap_q.
  assign w_tmr_load = ((r_state == ST_IDLE) && req && (gap_cfg != '0)) ||
                      ((r_state == ST_GRANT) && !w_final && req && (r_gap_q != '0));
  assign w_tmr_val  = (r_state == ST_IDLE) ? gap_cfg : r_gap_q;

  gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (r_state == ST_WAIT),
    .o_expire   (w_tmr_expire)
  );

  // Burst sequencing FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gap_q     <= '0;
      r_grant     <= 1'b0;
      r_grant_cnt <= '0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
      r_proto_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_grant <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      // Clear is applied first so a same-cycle error set below overrides it.
      if (clr_err) begin
        r_proto_err <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_gap_q <= gap_cfg;
            r_busy  <= 1'b1;
            if (gap_cfg == '0) begin
              r_state     <= ST_GRANT;
              r_grant     <= 1'b1;
              r_grant_cnt <= CNT_W'(1);
            end else begin
              r_state     <= ST_WAIT;
              r_grant_cnt <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            r_state <= ST_IDLE;
            r_abort <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_tmr_expire) begin
            r_state     <= ST_GRANT;
            r_grant     <= 1'b1;
            r_grant_cnt <= w_cnt_inc;
          end
        end
        ST_GRANT: begin
          if (w_final) begin
            r_state <= ST_CHECK;
          end else if (!req) begin
            r_state <= ST_IDLE;
            r_abort <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_gap_q == '0) begin
            r_grant     <= 1'b1;
            r_grant_cnt <= w_cnt_inc;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_CHECK: begin
          if (req) begin
            r_state     <= ST_HOLD;
            r_proto_err <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!req) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign grant_cnt = r_grant_cnt;
  assign done      = r_done;
  assign abort     = r_abort;
  assign proto_err = r_proto_err;
  assign busy      = r_busy;

endmodule
